seg7_scan_decoder: RTL and testbench

Reads a multiplexed 7-segment display bus (segment lines plus one-hot digit select) and reconstructs the BCD value shown on each digit. Sits on the output side of the clock's display path as a readback/self-check monitor: it consumes the same `abcdefg` encoding the display driver produces and returns per-digit BCD plus frame-complete and error flags. Each digit is captured only after its segment pattern has been stable for a programmable dwell, so scan transitions and ghosting are rejected.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_to_bcd.sv | 28 ++
 rtl/seg7_scan_decoder.sv | 138 +++++++++++++
 tb/tb_seg7_scan_decoder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: abcdefg patterns (bit 6 = a), BCD sentinel
// codes and the scan-decoder FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [3:0] BCD_INVALID = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational abcdefg -> BCD decode; blank maps to BCD_BLANK and any
// unrecognised pattern to BCD_INVALID.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd
);

    always_comb begin
        bcd = BCD_INVALID;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: bcd = BCD_BLANK;
            default:   bcd = BCD_INVALID;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Readback monitor for a multiplexed 7-segment bus: commits each digit's BCD
// value once its pattern has been stable for STABLE_CYCLES samples.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_en,
    input  logic [6:0]              i_seg,
    input  logic [NUM_DIGITS-1:0]   i_digit_sel,
    input  logic                    i_err_clr,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic [NUM_DIGITS-1:0]   o_digit_valid,
    output logic                    o_frame_stb,
    output logic                    o_err
);

    localparam int unsigned    CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_DONE = CW'(STABLE_CYCLES);

    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] sel_q;
    scan_state_t           state;
    logic [CW-1:0]         cnt;
    logic [NUM_DIGITS-1:0] mask;

    logic [3:0]            dec;
    int unsigned           sel_ones;
    logic                  sel_onehot;
    logic                  same_sample;
    logic                  commit;

    seg7_to_bcd u_dec (
        .seg (i_seg),
        .bcd (dec)
    );

    always_comb begin
        sel_ones = 0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i_digit_sel[i]) begin
                sel_ones = sel_ones + 1;
            end
        end
        sel_onehot = (sel_ones == 1);
    end

    // The incoming value is the sample being taken this edge; seg_q/sel_q hold
    // the previous one, so the count reaches 1 on the very edge that samples it.
    always_comb begin
        same_sample = (i_seg == seg_q) && (i_digit_sel == sel_q);
        commit      = i_en && sel_onehot && same_sample &&
                      (state == ST_SETTLE) && (cnt == CNT_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            seg_q         <= '0;
            sel_q         <= '0;
            state         <= ST_IDLE;
            cnt           <= '0;
            mask          <= '0;
            o_bcd         <= {NUM_DIGITS{BCD_BLANK}};
            o_digit_valid <= '0;
            o_frame_stb   <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            seg_q       <= i_seg;
            sel_q       <= i_digit_sel;
            o_frame_stb <= 1'b0;

            if (!i_en || !sel_onehot) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_SETTLE;
                        cnt   <= CNT_ONE;
                    end
                    ST_SETTLE: begin
                        if (!same_sample) begin
                            cnt <= CNT_ONE;
                        end else if (cnt == CNT_LAST) begin
                            state <= ST_HELD;
                            cnt   <= CNT_DONE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    ST_HELD: begin
                        if (!same_sample) begin
                            state <= ST_SETTLE;
                            cnt   <= CNT_ONE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end

            if (!i_en) begin
                mask <= '0;
            end else if (commit) begin
                if ((mask | i_digit_sel) == '1) begin
                    mask        <= '0;
                    o_frame_stb <= 1'b1;
                end else begin
                    mask <= mask | i_digit_sel;
                end
            end

            if (commit) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (i_digit_sel[i]) begin
                        o_bcd[4*i +: 4] <= dec;
                    end
                end
                o_digit_valid <= o_digit_valid | i_digit_sel;
            end

            // Set wins over clear when both land on the same edge.
            if (commit && dec == BCD_INVALID) begin
                o_err <= 1'b1;
            end else if (i_err_clr) begin
                o_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scan frames, dwell/glitch rejection,
// error flag, non-one-hot selects, reset and enable behaviour.
module tb_seg7_scan_decoder;

    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1111011;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [6:0]  seg;
    logic [5:0]  sel;
    logic        clr;
    logic [23:0] bcd;
    logic [5:0]  valid;
    logic        stb;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned stb_count = 0;
    int unsigned snap;
    logic [23:0] stb_bcd = '0;

    seg7_scan_decoder #(.NUM_DIGITS(6), .STABLE_CYCLES(4)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_en          (en),
        .i_seg         (seg),
        .i_digit_sel   (sel),
        .i_err_clr     (clr),
        .o_bcd         (bcd),
        .o_digit_valid (valid),
        .o_frame_stb   (stb),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stb) begin
            stb_count++;
            stb_bcd = bcd;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [5:0] s, input logic [6:0] p, input int n);
        sel = s;
        seg = p;
        tick(n);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; seg = '0; sel = '0; clr = 1'b0;
        tick(2);
        check("rst_bcd", bcd, 24'hFFFFFF);
        check("rst_valid", valid, 6'h00);
        check("rst_stb", stb, 1'b0);
        check("rst_err", err, 1'b0);

        rst = 1'b0; en = 1'b1;
        show(6'h01, P1, 8);
        show(6'h02, P2, 8);
        show(6'h04, P3, 8);
        show(6'h08, P4, 8);
        show(6'h10, P5, 8);
        show(6'h20, P9, 8);
        check("scan_bcd", bcd, 24'h954321);
        check("scan_valid", valid, 6'h3F);
        check("scan_stb_count", stb_count, 1);
        check("scan_stb_align", stb_bcd, 24'h954321);
        check("scan_err", err, 1'b0);

        // Commit lands exactly on the 4th sampling edge.
        show(6'h01, P7, 3);
        check("lat_pre", bcd[3:0], 4'd1);
        tick(1);
        check("lat_commit", bcd[3:0], 4'd7);

        sel = '0; rst = 1'b1; tick(1); rst = 1'b0;
        show(6'h04, P6, 3);
        show(6'h00, P6, 3);
        check("short_valid", valid, 6'h00);
        check("short_bcd", bcd[11:8], 4'hF);
        check("short_stb", stb_count, 1);

        show(6'h01, P0, 3);
        show(6'h01, P8, 1);
        show(6'h01, P0, 3);
        check("glitch_pre_bcd", bcd[3:0], 4'hF);
        check("glitch_pre_valid", valid[0], 1'b0);
        tick(1);
        check("glitch_bcd", bcd[3:0], 4'd0);
        check("glitch_valid", valid[0], 1'b1);

        show(6'h02, 7'b0000001, 4);
        check("inv_bcd", bcd[7:4], 4'hE);
        check("inv_err", err, 1'b1);
        clr = 1'b1; tick(1); clr = 1'b0;
        check("clr_err", err, 1'b0);
        show(6'h08, 7'b1000000, 3);
        clr = 1'b1; tick(1); clr = 1'b0;
        check("setwins_err", err, 1'b1);
        check("setwins_bcd", bcd[15:12], 4'hE);

        show(6'b000011, P8, 20);
        show(6'b000000, P8, 20);
        check("multi_bcd", bcd, 24'hFFEFE0);
        check("multi_valid", valid, 6'h0B);
        show(6'h10, P8, 4);
        check("after_multi_bcd", bcd, 24'hF8EFE0);
        check("after_multi_valid", valid, 6'h1B);
        check("after_multi_stb", stb_count, 1);

        show(6'h10, P2, 2);
        rst = 1'b1; tick(1);
        check("midrst_bcd", bcd, 24'hFFFFFF);
        check("midrst_valid", valid, 6'h00);
        check("midrst_err", err, 1'b0);
        check("midrst_stb", stb, 1'b0);
        rst = 1'b0; sel = '0;

        snap = stb_count;
        show(6'h01, P1, 6);
        show(6'h02, P2, 6);
        show(6'h04, P3, 6);
        en = 1'b0;
        show(6'h08, P4, 6);
        check("en0_bcd", bcd, 24'hFFF321);
        check("en0_valid", valid, 6'h07);
        en = 1'b1;
        show(6'h08, P4, 6);
        show(6'h10, P5, 6);
        show(6'h20, P6, 6);
        check("en1_partial_stb", stb_count, snap);
        check("en1_valid", valid, 6'h3F);
        show(6'h01, P7, 6);
        show(6'h02, P8, 6);
        check("en1_nearly_stb", stb_count, snap);
        show(6'h04, P9, 6);
        check("en1_frame_stb", stb_count, snap + 1);
        check("en1_bcd", bcd, 24'h654987);

        // Value change under an unchanged select is recaptured.
        show(6'h04, P3, 4);
        check("recap_bcd", bcd[11:8], 4'd3);
        check("recap_stb", stb_count, snap + 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
